// File: rtl/histogram_pkg.sv
// Shared types and constants for the histogram decompressor and its LFSR.
package histogram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_LFSR_SEED = 32'h0000_0001;

  function automatic int unsigned num_bins(input int unsigned num_streams);
    return 32'd1 << num_streams;
  endfunction

  // Maximal-length Fibonacci tap masks for the widths we expect to use.
  function automatic logic [31:0] default_lfsr_taps(input int unsigned width);
    logic [31:0] taps;
    case (width)
      32'd3:   taps = 32'h0000_0006;
      32'd4:   taps = 32'h0000_000C;
      32'd5:   taps = 32'h0000_0014;
      32'd6:   taps = 32'h0000_0030;
      32'd7:   taps = 32'h0000_0060;
      32'd8:   taps = 32'h0000_00B8;
      32'd16:  taps = 32'h0000_B400;
      default: taps = 32'h0000_00B8;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_fib.sv
// Fibonacci LFSR: shifts left, feedback is the parity of the tapped bits.
module lfsr_fib #(
  parameter int unsigned          WIDTH = 8,
  parameter logic [WIDTH-1:0]     TAPS  = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0]     SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (step) begin
      state <= {state[WIDTH-2:0], ^(state & TAPS)};
    end
  end

endmodule

// File: rtl/histogram_decompressor_nch.sv
// Expands a joint histogram into NUM_STREAMS correlated unary bitstreams,
// one symbol per cycle, with LFSR-randomised symbol order and valid/ready output.
module histogram_decompressor_nch
  import histogram_pkg::*;
#(
  parameter int unsigned          NUM_STREAMS   = 2,
  parameter int unsigned          STREAM_LENGTH = 128,
  parameter int unsigned          COUNTER_WIDTH = $clog2(STREAM_LENGTH + 1),
  parameter int unsigned          LFSR_WIDTH    = 8,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS    = LFSR_WIDTH'(default_lfsr_taps(LFSR_WIDTH)),
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED    = LFSR_WIDTH'(DEFAULT_LFSR_SEED)
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               start,
  input  logic                                               abort,
  input  logic [num_bins(NUM_STREAMS)*COUNTER_WIDTH-1:0]     counts,
  output logic [NUM_STREAMS-1:0]                             out_data,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic                                               busy,
  output logic                                               done,
  output logic                                               err
);

  localparam int unsigned NUM_BINS  = num_bins(NUM_STREAMS);
  localparam int unsigned CNT_VEC_W = NUM_BINS * COUNTER_WIDTH;
  localparam int unsigned SUM_W     = COUNTER_WIDTH + NUM_STREAMS;

  state_t                   state_q, state_d;
  logic [CNT_VEC_W-1:0]     cnt_q, cnt_d;
  logic [COUNTER_WIDTH-1:0] rem_q, rem_d;
  logic [NUM_STREAMS-1:0]   out_data_d;
  logic                     out_valid_d, busy_d, done_d, err_d;
  logic                     lfsr_load, lfsr_step;
  logic [LFSR_WIDTH-1:0]    lfsr_state;
  logic [SUM_W-1:0]         sum_c;
  logic [NUM_STREAMS-1:0]   sel_c;
  logic                     issue_c;

  // First nonzero bin scanning upward (with wrap) from the LFSR low bits.
  function automatic logic [NUM_STREAMS-1:0] pick_bin(
    input logic [CNT_VEC_W-1:0]  cnt,
    input logic [LFSR_WIDTH-1:0] lfsr
  );
    logic [NUM_STREAMS-1:0] idx;
    logic [NUM_STREAMS-1:0] sel;
    logic                   found;
    int unsigned            base;
    sel   = lfsr[NUM_STREAMS-1:0];
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_BINS; k++) begin
      idx  = lfsr[NUM_STREAMS-1:0] + NUM_STREAMS'(k);
      base = 32'(idx) * COUNTER_WIDTH;
      if (!found && (cnt[base +: COUNTER_WIDTH] != '0)) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  lfsr_fib #(
    .WIDTH (LFSR_WIDTH),
    .TAPS  (LFSR_TAPS),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

  // Sum is wide enough that NUM_BINS maximal counts cannot overflow.
  always_comb begin
    sum_c = '0;
    for (int unsigned b = 0; b < NUM_BINS; b++) begin
      sum_c = sum_c + SUM_W'(counts[b*COUNTER_WIDTH +: COUNTER_WIDTH]);
    end
  end

  assign sel_c   = pick_bin(cnt_q, lfsr_state);
  assign issue_c = (state_q == ST_RUN) && (!out_valid || out_ready) && (rem_q != '0);

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    done_d      = 1'b0;
    err_d       = 1'b0;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;

    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      rem_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (sum_c != SUM_W'(STREAM_LENGTH)) begin
              err_d = 1'b1;
            end else begin
              cnt_d     = counts;
              rem_d     = COUNTER_WIDTH'(STREAM_LENGTH);
              lfsr_load = 1'b1;
              state_d   = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (issue_c) begin
            out_data_d  = sel_c;
            out_valid_d = 1'b1;
            cnt_d[32'(sel_c)*COUNTER_WIDTH +: COUNTER_WIDTH] =
              cnt_q[32'(sel_c)*COUNTER_WIDTH +: COUNTER_WIDTH] - COUNTER_WIDTH'(1);
            rem_d       = rem_q - COUNTER_WIDTH'(1);
            lfsr_step   = 1'b1;
            if (rem_q == COUNTER_WIDTH'(1)) begin
              state_d = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_histogram_decompressor_nch.sv
// Randomised self-checking bench for histogram_decompressor_nch (2- and 3-stream builds).
module tb_histogram_decompressor_nch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start, abort, out_ready, sel3;
  logic [31:0] counts2;
  logic [55:0] counts3;
  logic [1:0]  od2;
  logic [2:0]  od3;
  logic        ov2, ov3, b2, b3, d2, d3, e2, e3;
  logic        st2, st3;
  logic [2:0]  m_data;
  logic        m_valid, m_busy, m_done, m_err;

  assign st2     = start & ~sel3;
  assign st3     = start & sel3;
  assign m_data  = sel3 ? od3 : {1'b0, od2};
  assign m_valid = sel3 ? ov3 : ov2;
  assign m_busy  = sel3 ? b3 : b2;
  assign m_done  = sel3 ? d3 : d2;
  assign m_err   = sel3 ? e3 : e2;

  histogram_decompressor_nch dut2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .abort(abort), .counts(counts2),
    .out_data(od2), .out_valid(ov2), .out_ready(out_ready),
    .busy(b2), .done(d2), .err(e2)
  );

  histogram_decompressor_nch #(.NUM_STREAMS(3), .STREAM_LENGTH(64)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(st3), .abort(abort), .counts(counts3),
    .out_data(od3), .out_valid(ov3), .out_ready(out_ready),
    .busy(b3), .done(d3), .err(e3)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int exp_q[$];
  int got_q[$];
  int ref_q[$];
  int first_valid, done_cyc, stall_viol, gap_cnt, done_after_abort;
  logic busy_at_done, abort_valid_after, abort_busy_after;

  // Reference: replay the symbol order from the spec rules using plain integers.
  function automatic void build_expected(input int ns, input int c_in[8]);
    int c[8];
    int unsigned s;
    int nb, total, st, b, idx;
    c = c_in;
    s = 1;
    nb = 1 << ns;
    total = 0;
    for (int i = 0; i < nb; i++) total += c[i];
    exp_q.delete();
    for (int n = 0; n < total; n++) begin
      st = int'(s % nb);
      b = -1;
      for (int k = 0; k < nb; k++) begin
        idx = (st + k) % nb;
        if (b < 0 && c[idx] > 0) b = idx;
      end
      exp_q.push_back(b);
      c[b]--;
      s = ((s << 1) & 32'hFF) | ($countones(s & 32'hB8) & 1);
    end
  endfunction

  function automatic int tally(input int q[$], input int v);
    int n = 0;
    foreach (q[i]) if (q[i] == v) n++;
    return n;
  endfunction

  function automatic int first_diff(input int a[$], input int b[$]);
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] != b[i]) return i;
    if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
    return -1;
  endfunction

  task automatic load_counts(input int ns, input int c[8]);
    sel3 = (ns == 3);
    for (int b = 0; b < 4; b++) counts2[b*8 +: 8] = 8'(c[b]);
    for (int b = 0; b < 8; b++) counts3[b*7 +: 7] = 7'(c[b]);
  endtask

  // Start a run and record every accepted symbol; cycle index counts edges after start is sampled.
  task automatic run_once(input bit rand_ready, input int abort_at, input int budget);
    int cyc;
    bit prev_stall;
    logic [2:0] prev_data;
    got_q.delete();
    first_valid = -1; done_cyc = -1; stall_viol = 0; gap_cnt = 0; done_after_abort = 0;
    busy_at_done = 1'b1; abort_valid_after = 1'b1; abort_busy_after = 1'b1;
    prev_stall = 1'b0; prev_data = '0;
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 0;
    while (cyc < budget) begin
      if (m_done) begin done_cyc = cyc; busy_at_done = m_busy; break; end
      if (prev_stall && (!m_valid || m_data != prev_data)) stall_viol++;
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (!m_valid && first_valid >= 0) gap_cnt++;
      if (abort_at >= 0 && m_valid && got_q.size() == abort_at) begin
        abort = 1'b1; out_ready = 1'b1;
        @(negedge clk); abort = 1'b0;
        abort_valid_after = m_valid; abort_busy_after = m_busy;
        repeat (5) begin @(negedge clk); if (m_done || m_valid) done_after_abort++; end
        return;
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && out_ready) got_q.push_back(int'(m_data));
      prev_stall = m_valid && !out_ready;
      prev_data = m_data;
      @(negedge clk); cyc++;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    n_cmp++; if ({od2, ov2, b2, d2, e2} !== 6'b0) begin n_fail++; $display("FAIL reset_dut2: got %b expected 000000", {od2, ov2, b2, d2, e2}); end
    n_cmp++; if ({od3, ov3, b3, d3, e3} !== 7'b0) begin n_fail++; $display("FAIL reset_dut3: got %b expected 0000000", {od3, ov3, b3, d3, e3}); end
  endtask

  task automatic test_uniform();
    int c[8] = '{32, 32, 32, 32, 0, 0, 0, 0};
    load_counts(2, c); build_expected(2, c);
    run_once(1'b0, -1, 400);
    n_cmp++; if (got_q.size() != 128) begin n_fail++; $display("FAIL uniform_len: got %0d expected 128", got_q.size()); end
    for (int b = 0; b < 4; b++) begin
      n_cmp++; if (tally(got_q, b) != 32) begin n_fail++; $display("FAIL uniform_bin%0d: got %0d expected 32", b, tally(got_q, b)); end
    end
    n_cmp++; if (first_diff(got_q, exp_q) != -1) begin n_fail++; $display("FAIL uniform_seq: diff at %0d expected none", first_diff(got_q, exp_q)); end
    n_cmp++; if (first_valid != 1) begin n_fail++; $display("FAIL uniform_latency: got %0d expected 1", first_valid); end
    n_cmp++; if (done_cyc != 129) begin n_fail++; $display("FAIL uniform_done_cycle: got %0d expected 129", done_cyc); end
    n_cmp++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL uniform_busy_after: got %b expected 0", busy_at_done); end
    n_cmp++; if (gap_cnt != 0) begin n_fail++; $display("FAIL uniform_gaps: got %0d expected 0", gap_cnt); end
  endtask

  task automatic test_single_bin();
    int c[8] = '{0, 0, 0, 128, 0, 0, 0, 0};
    load_counts(2, c);
    run_once(1'b0, -1, 400);
    n_cmp++; if (tally(got_q, 3) != 128 || got_q.size() != 128) begin n_fail++; $display("FAIL single_bin_count: got %0d of %0d expected 128", tally(got_q, 3), got_q.size()); end
    n_cmp++; if (gap_cnt != 0) begin n_fail++; $display("FAIL single_bin_gaps: got %0d expected 0", gap_cnt); end
    n_cmp++; if (done_cyc != 129) begin n_fail++; $display("FAIL single_bin_done: got %0d expected 129", done_cyc); end
  endtask

  task automatic test_bad_sum();
    int sets[2][8] = '{'{30, 32, 32, 33, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}};
    int bad;
    for (int t = 0; t < 2; t++) begin
      load_counts(2, sets[t]);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n_cmp++; if (m_err !== 1'b1) begin n_fail++; $display("FAIL bad_sum%0d_err: got %b expected 1", t, m_err); end
      n_cmp++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL bad_sum%0d_busy: got %b expected 0", t, m_busy); end
      bad = 0;
      @(negedge clk);
      n_cmp++; if (m_err !== 1'b0) begin n_fail++; $display("FAIL bad_sum%0d_err_pulse: got %b expected 0", t, m_err); end
      repeat (10) begin if (m_valid || m_busy) bad++; @(negedge clk); end
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL bad_sum%0d_quiet: got %0d active cycles expected 0", t, bad); end
    end
  endtask

  task automatic test_backpressure();
    int c[8] = '{10, 50, 60, 8, 0, 0, 0, 0};
    load_counts(2, c); build_expected(2, c);
    run_once(1'b0, -1, 400);
    ref_q = got_q;
    run_once(1'b1, -1, 2000);
    n_cmp++; if (first_diff(got_q, ref_q) != -1) begin n_fail++; $display("FAIL bp_vs_ready_run: diff at %0d expected none", first_diff(got_q, ref_q)); end
    n_cmp++; if (first_diff(got_q, exp_q) != -1) begin n_fail++; $display("FAIL bp_vs_model: diff at %0d expected none", first_diff(got_q, exp_q)); end
    for (int b = 0; b < 4; b++) begin
      n_cmp++; if (tally(got_q, b) != c[b]) begin n_fail++; $display("FAIL bp_bin%0d: got %0d expected %0d", b, tally(got_q, b), c[b]); end
    end
    n_cmp++; if (stall_viol != 0) begin n_fail++; $display("FAIL bp_stall_hold: got %0d violations expected 0", stall_viol); end
    n_cmp++; if (done_cyc < 0) begin n_fail++; $display("FAIL bp_done: got timeout expected done"); end
  endtask

  task automatic test_abort();
    int c[8] = '{10, 50, 60, 8, 0, 0, 0, 0};
    int pre[$];
    load_counts(2, c); build_expected(2, c);
    run_once(1'b0, 40, 400);
    pre = exp_q[0:39];
    n_cmp++; if (abort_valid_after !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b expected 0", abort_valid_after); end
    n_cmp++; if (abort_busy_after !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", abort_busy_after); end
    n_cmp++; if (done_after_abort != 0) begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles expected 0", done_after_abort); end
    n_cmp++; if (first_diff(got_q, pre) != -1) begin n_fail++; $display("FAIL abort_prefix: diff at %0d expected none", first_diff(got_q, pre)); end
    run_once(1'b0, -1, 400);
    n_cmp++; if (first_diff(got_q, exp_q) != -1) begin n_fail++; $display("FAIL abort_restart: diff at %0d expected none", first_diff(got_q, exp_q)); end
  endtask

  task automatic test_random_counts();
    int c[8];
    for (int it = 0; it < 3; it++) begin
      c = '{default: 0};
      c[0] = $urandom_range(0, 128);
      c[1] = $urandom_range(0, 128 - c[0]);
      c[2] = $urandom_range(0, 128 - c[0] - c[1]);
      c[3] = 128 - c[0] - c[1] - c[2];
      load_counts(2, c); build_expected(2, c);
      run_once(1'b1, -1, 2000);
      n_cmp++; if (first_diff(got_q, exp_q) != -1) begin n_fail++; $display("FAIL rand%0d_seq: diff at %0d expected none", it, first_diff(got_q, exp_q)); end
      n_cmp++; if (stall_viol != 0 || gap_cnt != 0) begin n_fail++; $display("FAIL rand%0d_flow: got %0d/%0d expected 0/0", it, stall_viol, gap_cnt); end
    end
  endtask

  task automatic test_three_streams();
    int c[8] = '{8, 8, 8, 8, 8, 8, 8, 8};
    load_counts(3, c); build_expected(3, c);
    run_once(1'b0, -1, 300);
    for (int b = 0; b < 8; b++) begin
      n_cmp++; if (tally(got_q, b) != 8) begin n_fail++; $display("FAIL ns3_bin%0d: got %0d expected 8", b, tally(got_q, b)); end
    end
    n_cmp++; if (first_diff(got_q, exp_q) != -1) begin n_fail++; $display("FAIL ns3_seq: diff at %0d expected none", first_diff(got_q, exp_q)); end
    n_cmp++; if (done_cyc != 65) begin n_fail++; $display("FAIL ns3_done: got %0d expected 65", done_cyc); end
  endtask

  task automatic test_async_reset();
    int c[8] = '{8, 8, 8, 8, 8, 8, 8, 8};
    load_counts(3, c); build_expected(3, c);
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++; if ({m_valid, m_busy} !== 2'b11) begin n_fail++; $display("FAIL ns3_midrun: got %b expected 11", {m_valid, m_busy}); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({od3, ov3, b3, d3, e3} !== 7'b0) begin n_fail++; $display("FAIL async_reset: got %b expected 0000000", {od3, ov3, b3, d3, e3}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_once(1'b0, -1, 300);
    n_cmp++; if (first_diff(got_q, exp_q) != -1) begin n_fail++; $display("FAIL post_reset_seq: diff at %0d expected none", first_diff(got_q, exp_q)); end
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; out_ready = 1'b1; sel3 = 1'b0;
    counts2 = '0; counts3 = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_uniform();
    test_single_bin();
    test_bad_sum();
    test_backpressure();
    test_abort();
    test_random_counts();
    test_three_streams();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
